// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch queue: FSM state, queue entry, word size.
package fetch_pkg;

    typedef enum logic [1:0] {
        FQ_IDLE,
        FQ_REQ,
        FQ_FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Purpose: DEPTH-entry circular store of {pc,instr} pairs with synchronous clear.
// Latency: push visible at head one cycle later; head is a plain register read.
// Backpressure: caller never pushes when full; a pop while empty is ignored.
module fetch_queue_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             push_dat,
    input  logic                     pop,
    output fetch_entry_t             head_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t       mem [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic               do_pop;

    assign do_pop   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Purpose: sequential instruction prefetch ahead of decode; optional FETCH_BYPASS_EN forwards an empty-queue response straight to decode.
// Latency: bus response to deq_valid_o is 1 cycle (0 with FETCH_BYPASS_EN and an empty queue).
// Backpressure: requests stop while the registered count is DEPTH or halt_i is high; one outstanding request.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
    parameter int          DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     halt_i,
    input  logic                     flush_i,
    input  logic [31:0]              flush_pc_i,
    output logic                     instr_flush_o,
    output logic                     instr_req_o,
    input  logic                     instr_rsp_i,
    input  logic [31:0]              instr_data_i,
    output logic [31:0]              instr_addr_o,
    output logic                     deq_valid_o,
    input  logic                     deq_ready_i,
    output logic [31:0]              deq_instr_o,
    output logic [31:0]              deq_pc_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t   state;
    fetch_state_t   state_nxt;
    logic [31:0]    fetch_pc;
    logic [CW-1:0]  count;
    fetch_entry_t   head;
    fetch_entry_t   wr_entry;
    logic           rsp_take;
    logic           has_space;
    logic           push;

    assign rsp_take  = (state == FQ_REQ) && instr_rsp_i && !flush_i;
    // Space is judged on the registered count; a same-cycle pop does not count.
    assign has_space = count < CW'(DEPTH);
    assign wr_entry  = '{pc: fetch_pc, instr: instr_data_i};

    always_comb begin
        state_nxt = state;
        case (state)
            FQ_IDLE:  if (!halt_i && has_space) state_nxt = FQ_REQ;
            FQ_REQ:   if (instr_rsp_i)          state_nxt = FQ_IDLE;
            FQ_FLUSH:                           state_nxt = FQ_IDLE;
            default:                            state_nxt = FQ_IDLE;
        endcase
        if (flush_i) begin
            state_nxt = FQ_FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FQ_IDLE;
            fetch_pc <= BOOT_ADDRESS;
        end else begin
            state <= state_nxt;
            if (flush_i) begin
                fetch_pc <= flush_pc_i & ~32'h3;
            end else if (rsp_take) begin
                fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
            end
        end
    end

`ifdef FETCH_BYPASS_EN
    logic bypass;

    assign bypass      = (count == '0) && rsp_take;
    // A bypassed word that decode takes immediately never occupies a slot.
    assign push        = rsp_take && !(bypass && deq_ready_i);
    assign deq_valid_o = (count != '0) || bypass;
    assign deq_instr_o = bypass ? instr_data_i : head.instr;
    assign deq_pc_o    = bypass ? fetch_pc     : head.pc;
`else
    assign push        = rsp_take;
    assign deq_valid_o = (count != '0);
    assign deq_instr_o = head.instr;
    assign deq_pc_o    = head.pc;
`endif

    fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (flush_i),
        .push     (push),
        .push_dat (wr_entry),
        .pop      (deq_ready_i),
        .head_dat (head),
        .count    (count)
    );

    assign instr_req_o   = (state == FQ_REQ);
    assign instr_flush_o = (state == FQ_FLUSH);
    assign instr_addr_o  = fetch_pc;
    assign level_o       = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: queue-level reference model checked every cycle plus literal spot checks.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BOOT  = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        rsp = 1'b0;
    logic [31:0] data = '0;
    logic        ready = 1'b0;

    logic        instr_flush_o, instr_req_o, deq_valid_o;
    logic [31:0] instr_addr_o, deq_instr_o, deq_pc_o;
    logic [2:0]  level_o;

    fetch_queue #(.BOOT_ADDRESS(BOOT), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .halt_i        (halt),
        .flush_i       (flush),
        .flush_pc_i    (flush_pc),
        .instr_flush_o (instr_flush_o),
        .instr_req_o   (instr_req_o),
        .instr_rsp_i   (rsp),
        .instr_data_i  (data),
        .instr_addr_o  (instr_addr_o),
        .deq_valid_o   (deq_valid_o),
        .deq_ready_i   (ready),
        .deq_instr_o   (deq_instr_o),
        .deq_pc_o      (deq_pc_o),
        .level_o       (level_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {pc,instr}, an outstanding-request flag and a flush-pulse flag.
    logic [63:0] m_q[$];
    logic [31:0] m_pc = BOOT;
    bit          m_out = 0;
    bit          m_fl = 0;
    int          wcnt = 0;
    int          m_sz;
    bit          m_byp;
    bit          m_was;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_pc  = BOOT;
            m_out = 0;
            m_fl  = 0;
            wcnt  = 0;
        end else begin
            m_sz  = m_q.size();
            m_was = m_out;
            m_byp = BYP && (m_sz == 0) && m_out && rsp && !flush;
            if (flush) begin
                m_q.delete();
                m_pc  = flush_pc & ~32'h3;
                m_out = 0;
                m_fl  = 1;
            end else begin
                if (ready && m_sz != 0) void'(m_q.pop_front());
                if (m_fl) begin
                    m_fl = 0;
                end else if (m_out) begin
                    if (rsp) begin
                        if (!(m_byp && ready)) m_q.push_back({m_pc, data});
                        m_pc  = m_pc + 32'd4;
                        m_out = 0;
                    end
                end else if (!halt && m_sz < DEPTH) begin
                    m_out = 1;
                end
            end
            wcnt = (m_was && m_out) ? wcnt + 1 : 0;
        end
    end

    // Every-cycle compare against the model; also logs accepted fetch addresses.
    bit          cmp_en = 0;
    logic [31:0] got_addr[$];
    bit          e_byp, e_vld;

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            e_byp = BYP && (m_q.size() == 0) && m_out && rsp && !flush;
            e_vld = (m_q.size() != 0) || e_byp;
            chk("req",   {31'd0, instr_req_o},   {31'd0, m_out});
            chk("flush", {31'd0, instr_flush_o}, {31'd0, m_fl});
            chk("addr",  instr_addr_o, m_pc);
            chk("level", {29'd0, level_o}, 32'(m_q.size()));
            chk("valid", {31'd0, deq_valid_o}, {31'd0, e_vld});
            if (e_byp) begin
                chk("byp_instr", deq_instr_o, data);
                chk("byp_pc",    deq_pc_o,    m_pc);
            end else if (e_vld) begin
                chk("head_instr", deq_instr_o, m_q[0][31:0]);
                chk("head_pc",    deq_pc_o,    m_q[0][63:32]);
            end
            if (instr_req_o && rsp && !flush) got_addr.push_back(instr_addr_o);
        end
    end

    int          lat = 0;
    bit          dovr = 0;
    logic [31:0] dval = '0;

    task automatic drive_rsp();
        rsp  = m_out && (wcnt >= lat);
        data = dovr ? dval : (m_pc ^ 32'hDEAD_0000);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
            flush = 1'b0;
            drive_rsp();
        end
    endtask

    task automatic wait_rsp(input string nm);
        for (int k = 0; k < 40 && !rsp; k++) step(1);
        if (!rsp) begin
            total++; bad++;
            $display("FAIL %s: timeout waiting for response cycle", nm);
        end
    endtask

    task automatic wait_out(input string nm);
        for (int k = 0; k < 40 && !m_out; k++) step(1);
        if (!m_out) begin
            total++; bad++;
            $display("FAIL %s: timeout waiting for request cycle", nm);
        end
    endtask

    initial begin
        // Reset values
        #3;
        chk("rst_req",   {31'd0, instr_req_o},   32'd0);
        chk("rst_flush", {31'd0, instr_flush_o}, 32'd0);
        chk("rst_valid", {31'd0, deq_valid_o},   32'd0);
        chk("rst_level", {29'd0, level_o},       32'd0);
        chk("rst_addr",  instr_addr_o, BOOT);
        chk("rst_instr", deq_instr_o,  32'd0);
        chk("rst_pc",    deq_pc_o,     32'd0);
        step(2);
        rst_n  = 1'b1;
        cmp_en = 1;

        // Fill with ready low: 0,4,8,C then requests stop
        step(20);
        chk("t1_level", {29'd0, level_o}, 32'd4);
        chk("t1_req",   {31'd0, instr_req_o}, 32'd0);
        chk("t1_nfetch", 32'(got_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t1_fetch_addr", got_addr[i], 32'(i * 4));
        chk("t1_head_instr", deq_instr_o, 32'hDEAD_0000);

        // One pop from full: head pc 0, request 0x10 follows one cycle later
        ready = 1'b1;
        chk("t2_head_pc", deq_pc_o, 32'h0);
        step(1);
        ready = 1'b0;
        chk("t2_level", {29'd0, level_o}, 32'd3);
        chk("t2_req_wait", {31'd0, instr_req_o}, 32'd0);
        chk("t2_next_head", deq_pc_o, 32'h4);
        step(1);
        chk("t2_req", {31'd0, instr_req_o}, 32'd1);
        chk("t2_addr", instr_addr_o, 32'h10);

        // Flush to 0x203 while the response arrives in the same cycle
        chk("t3_rsp_live", {31'd0, rsp}, 32'd1);
        flush = 1'b1; flush_pc = 32'h203;
        step(1);
        chk("t3_flush_o", {31'd0, instr_flush_o}, 32'd1);
        chk("t3_req", {31'd0, instr_req_o}, 32'd0);
        chk("t3_level", {29'd0, level_o}, 32'd0);
        chk("t3_valid", {31'd0, deq_valid_o}, 32'd0);
        step(1);
        chk("t3_flush_end", {31'd0, instr_flush_o}, 32'd0);
        step(1);
        chk("t3_req2", {31'd0, instr_req_o}, 32'd1);
        chk("t3_addr", instr_addr_o, 32'h200);

        // halt during a request: that response is stored, then no further requests
        lat = 3;
        flush = 1'b1; flush_pc = 32'h1000;
        step(3);
        chk("t4_in_req", {31'd0, instr_req_o}, 32'd1);
        halt = 1'b1;
        step(8);
        chk("t4_level", {29'd0, level_o}, 32'd1);
        chk("t4_req", {31'd0, instr_req_o}, 32'd0);
        chk("t4_head_pc", deq_pc_o, 32'h1000);
        chk("t4_head_instr", deq_instr_o, 32'hDEAD_1000);
        halt = 1'b0;
        step(1);
        chk("t4_resume", {31'd0, instr_req_o}, 32'd1);
        chk("t4_addr", instr_addr_o, 32'h1004);

        // Empty queue, data 0x13, ready high
        dovr = 1; dval = 32'h0000_0013; ready = 1'b1; lat = 2;
        flush = 1'b1; flush_pc = 32'h300;
        step(1);
        wait_rsp("t5_wait");
        #1;
        chk("t5_valid_n", {31'd0, deq_valid_o}, {31'd0, BYP});
        if (BYP) begin
            chk("t5_byp_instr", deq_instr_o, 32'h13);
            chk("t5_byp_pc", deq_pc_o, 32'h300);
        end
        step(1);
        dovr = 0;
        chk("t5_level", {29'd0, level_o}, BYP ? 32'd0 : 32'd1);
        chk("t5_valid_n1", {31'd0, deq_valid_o}, BYP ? 32'd0 : 32'd1);
        if (!BYP) chk("t5_instr_n1", deq_instr_o, 32'h13);

        // Reset in the middle of a request
        ready = 1'b0; lat = 5;
        wait_out("t6_wait");
        #1;
        chk("t6_in_req", {31'd0, instr_req_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_req", {31'd0, instr_req_o}, 32'd0);
        chk("t6_flush", {31'd0, instr_flush_o}, 32'd0);
        chk("t6_valid", {31'd0, deq_valid_o}, 32'd0);
        chk("t6_level", {29'd0, level_o}, 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        wait_out("t6_wait2");
        chk("t6_boot_req", {31'd0, instr_req_o}, 32'd1);
        chk("t6_boot_addr", instr_addr_o, BOOT);

        // Low address bits forced clear and fetch pc wrap past the top of memory
        lat = 0; ready = 1'b1;
        flush = 1'b1; flush_pc = 32'hFFFF_FFFE;
        step(1);
        chk("t7_flush_addr", instr_addr_o, 32'hFFFF_FFFC);
        step(2);
        chk("t7_req_top", {31'd0, instr_req_o}, 32'd1);
        chk("t7_addr_top", instr_addr_o, 32'hFFFF_FFFC);
        step(2);
        chk("t7_req_wrap", {31'd0, instr_req_o}, 32'd1);
        chk("t7_addr_wrap", instr_addr_o, 32'h0);
        step(4);

        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
